// File: rtl/pipe_pkg.sv
// Shared EX->MEM pipeline definitions.
// Default field widths and the packed payload bundle.
package pipe_pkg;

    localparam int DEF_WB_W   = 2;
    localparam int DEF_M_W    = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    typedef struct packed {
        logic [DEF_WB_W-1:0]   wb;
        logic [DEF_M_W-1:0]    m;
        logic [DEF_DATA_W-1:0] alu_result;
        logic [DEF_DATA_W-1:0] mem_data;
        logic [DEF_REG_W-1:0]  write_reg;
        logic [DEF_REG_W-1:0]  rd;
    } ex_mem_t;

    localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/pipe_payload_reg.sv
// Load-enable payload register.
// Cleared by reset, otherwise holds until loaded.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture payload on load, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with valid/ready, flush and optional skid.
// Control only here; payload storage lives in pipe_payload_reg.
module ex_mem_stage_reg
    import pipe_pkg::*;
#(
    parameter int WB_W   = DEF_WB_W,
    parameter int M_W    = DEF_M_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   WB_in,
    input  logic [M_W-1:0]    M_in,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [DATA_W-1:0] write_mem_data_in,
    input  logic [REG_W-1:0]  write_register_in,
    input  logic [REG_W-1:0]  Rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   WB_out,
    output logic [M_W-1:0]    M_out,
    output logic [DATA_W-1:0] ALUresult_out,
    output logic [DATA_W-1:0] write_mem_data_out,
    output logic [REG_W-1:0]  write_register_out,
    output logic [REG_W-1:0]  Rd_out,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_data;
        logic [REG_W-1:0]  write_reg;
        logic [REG_W-1:0]  rd;
    } payload_t;

    localparam int PW = $bits(payload_t);

    payload_t in_p;
    payload_t main_d;
    payload_t main_q;
    payload_t skid_q;

    logic main_valid;
    logic skid_valid;
    logic accept;
    logic drain;
    logic main_load;

    assign in_p = {WB_in, M_in, ALUresult_in, write_mem_data_in,
                   write_register_in, Rd_in};

    assign accept = in_valid & in_ready;
    assign drain  = main_valid & out_ready;

    // A held skid entry always refills main on drain; else input does
    assign main_load = ~flush &
                       (skid_valid ? drain
                                   : (accept & (~main_valid | drain)));
    assign main_d    = skid_valid ? skid_q : in_p;

    // Main entry valid flag
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
        end else if (main_load) begin
            main_valid <= 1'b1;
        end else if (drain) begin
            main_valid <= 1'b0;
        end
    end

    pipe_payload_reg #(
        .W(PW)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    if (SKID) begin : g_skid
        logic skid_load;
        logic in_ready_q;

        assign skid_load = ~flush & ~skid_valid & accept &
                           main_valid & ~drain;

        // Skid flag with ready registered as its complement
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                skid_valid <= 1'b0;
                in_ready_q <= 1'b1;
            end else if (skid_load) begin
                skid_valid <= 1'b1;
                in_ready_q <= 1'b0;
            end else if (skid_valid && drain) begin
                skid_valid <= 1'b0;
                in_ready_q <= 1'b1;
            end
        end

        pipe_payload_reg #(
            .W(PW)
        ) u_skid (
            .clk  (clk),
            .rst  (rst),
            .load (skid_load),
            .d    (in_p),
            .q    (skid_q)
        );

        assign in_ready = in_ready_q;
    end else begin : g_single
        assign skid_valid = 1'b0;
        assign skid_q     = '0;
        assign in_ready   = ~main_valid | out_ready;
    end

    assign out_valid          = main_valid;
    assign WB_out             = main_valid ? main_q.wb : '0;
    assign M_out              = main_valid ? main_q.m  : '0;
    assign ALUresult_out      = main_q.alu_result;
    assign write_mem_data_out = main_q.mem_data;
    assign write_register_out = main_q.write_reg;
    assign Rd_out             = main_q.rd;
    assign occupancy          = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed and scoreboard checks for ex_mem_stage_reg.
// Two instances share inputs: SKID=1 (d1) and SKID=0 (d0).
module tb_ex_mem_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [1:0]  wb_in, m_in;
    logic [31:0] alu_in, wd_in;
    logic [4:0]  wr_in, rd_in;

    logic        rdy1, ov1, rdy0, ov0;
    logic [1:0]  wb1, m1, occ1, wb0, m0, occ0;
    logic [31:0] alu1, wd1, alu0, wd0;
    logic [4:0]  wr1, rd1, wr0, rd0;

    int total = 0;
    int bad   = 0;

    logic [33:0] q1[$];
    logic [33:0] q0[$];

    ex_mem_stage_reg #(.SKID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1),
        .WB_in(wb_in), .M_in(m_in), .ALUresult_in(alu_in),
        .write_mem_data_in(wd_in), .write_register_in(wr_in), .Rd_in(rd_in),
        .out_valid(ov1), .out_ready(out_ready),
        .WB_out(wb1), .M_out(m1), .ALUresult_out(alu1),
        .write_mem_data_out(wd1), .write_register_out(wr1), .Rd_out(rd1),
        .occupancy(occ1)
    );

    ex_mem_stage_reg #(.SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0),
        .WB_in(wb_in), .M_in(m_in), .ALUresult_in(alu_in),
        .write_mem_data_in(wd_in), .write_register_in(wr_in), .Rd_in(rd_in),
        .out_valid(ov0), .out_ready(out_ready),
        .WB_out(wb0), .M_out(m0), .ALUresult_out(alu0),
        .write_mem_data_out(wd0), .write_register_out(wr0), .Rd_out(rd0),
        .occupancy(occ0)
    );

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        wb_in = '0; m_in = '0; alu_in = '0; wd_in = '0; wr_in = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL rst_ov1 got=%0h exp=0", ov1); end
        total++; if (wb1 !== 2'd0) begin bad++; $display("FAIL rst_wb1 got=%0h exp=0", wb1); end
        total++; if (m1 !== 2'd0) begin bad++; $display("FAIL rst_m1 got=%0h exp=0", m1); end
        total++; if (occ1 !== 2'd0) begin bad++; $display("FAIL rst_occ1 got=%0h exp=0", occ1); end
        total++; if (alu1 !== 32'd0) begin bad++; $display("FAIL rst_alu1 got=%0h exp=0", alu1); end
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_ov0 got=%0h exp=0", ov0); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL rst_rdy1 got=%0h exp=1", rdy1); end
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL rst_rdy0 got=%0h exp=1", rdy0); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1; in_valid = 1'b1; wb_in = 2'b01; m_in = 2'b10;
        for (int i = 1; i <= 4; i++) begin
            alu_in = 32'(i); wr_in = 5'(i); rd_in = 5'(i + 8);
            @(negedge clk);
            total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL str_ov1 got=%0h exp=1", ov1); end
            total++; if (alu1 !== 32'(i)) begin bad++; $display("FAIL str_alu1 got=%0h exp=%0h", alu1, i); end
            total++; if (wb1 !== 2'b01) begin bad++; $display("FAIL str_wb1 got=%0h exp=1", wb1); end
            total++; if (m1 !== 2'b10) begin bad++; $display("FAIL str_m1 got=%0h exp=2", m1); end
            total++; if (wr1 !== 5'(i)) begin bad++; $display("FAIL str_wr1 got=%0h exp=%0h", wr1, i); end
            total++; if (rd1 !== 5'(i + 8)) begin bad++; $display("FAIL str_rd1 got=%0h exp=%0h", rd1, i + 8); end
            total++; if (occ1 !== 2'd1) begin bad++; $display("FAIL str_occ1 got=%0h exp=1", occ1); end
            total++; if (alu0 !== 32'(i)) begin bad++; $display("FAIL str_alu0 got=%0h exp=%0h", alu0, i); end
            total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL str_ov0 got=%0h exp=1", ov0); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL str_end_ov1 got=%0h exp=0", ov1); end
        total++; if (wb1 !== 2'd0) begin bad++; $display("FAIL str_end_wb1 got=%0h exp=0", wb1); end
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL str_end_ov0 got=%0h exp=0", ov0); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0; in_valid = 1'b1; wb_in = 2'b11; m_in = 2'b01;
        alu_in = 32'hA;
        @(negedge clk);
        total++; if (occ1 !== 2'd1) begin bad++; $display("FAIL skid_occ_a got=%0h exp=1", occ1); end
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL skid_rdy_a got=%0h exp=1", rdy1); end
        total++; if (alu1 !== 32'hA) begin bad++; $display("FAIL skid_alu_a got=%0h exp=a", alu1); end
        alu_in = 32'hB;
        @(negedge clk);
        total++; if (occ1 !== 2'd2) begin bad++; $display("FAIL skid_occ_ab got=%0h exp=2", occ1); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL skid_rdy_ab got=%0h exp=0", rdy1); end
        total++; if (alu1 !== 32'hA) begin bad++; $display("FAIL skid_hold_a got=%0h exp=a", alu1); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++; if (alu1 !== 32'hB) begin bad++; $display("FAIL skid_alu_b got=%0h exp=b", alu1); end
        total++; if (occ1 !== 2'd1) begin bad++; $display("FAIL skid_occ_b got=%0h exp=1", occ1); end
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL skid_rdy_b got=%0h exp=1", rdy1); end
        total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL skid_ov_b got=%0h exp=1", ov1); end
        @(negedge clk);
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL skid_empty_ov got=%0h exp=0", ov1); end
        total++; if (occ1 !== 2'd0) begin bad++; $display("FAIL skid_empty_occ got=%0h exp=0", occ1); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; wb_in = 2'b01; m_in = 2'b01; alu_in = 32'h11;
        @(negedge clk);
        alu_in = 32'h22;
        @(negedge clk);
        total++; if (occ1 !== 2'd2) begin bad++; $display("FAIL fl_pre_occ got=%0h exp=2", occ1); end
        alu_in = 32'h33; wb_in = 2'b11; m_in = 2'b11; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL fl_ov1 got=%0h exp=0", ov1); end
        total++; if (wb1 !== 2'd0) begin bad++; $display("FAIL fl_wb1 got=%0h exp=0", wb1); end
        total++; if (m1 !== 2'd0) begin bad++; $display("FAIL fl_m1 got=%0h exp=0", m1); end
        total++; if (occ1 !== 2'd0) begin bad++; $display("FAIL fl_occ1 got=%0h exp=0", occ1); end
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL fl_rdy1 got=%0h exp=1", rdy1); end
        total++; if (alu1 !== 32'h11) begin bad++; $display("FAIL fl_hold_alu got=%0h exp=11", alu1); end
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL fl_ov0 got=%0h exp=0", ov0); end
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL fl_ghost got=%0h exp=0", ov1); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        in_valid = 1'b1; wb_in = 2'b10; m_in = 2'b01; alu_in = 32'h44;
        @(negedge clk);
        alu_in = 32'h55;
        @(negedge clk);
        total++; if (occ1 !== 2'd2) begin bad++; $display("FAIL rm_pre_occ got=%0h exp=2", occ1); end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL rm_ov1 got=%0h exp=0", ov1); end
        total++; if (occ1 !== 2'd0) begin bad++; $display("FAIL rm_occ1 got=%0h exp=0", occ1); end
        total++; if (alu1 !== 32'd0) begin bad++; $display("FAIL rm_alu1 got=%0h exp=0", alu1); end
        total++; if (rd1 !== 5'd0) begin bad++; $display("FAIL rm_rd1 got=%0h exp=0", rd1); end
        total++; if (wb1 !== 2'd0) begin bad++; $display("FAIL rm_wb1 got=%0h exp=0", wb1); end
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL rm_rdy1 got=%0h exp=1", rdy1); end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic er1, er0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q1.delete(); q0.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            alu_in    = 32'(c + 100);
            wb_in     = 2'(c) | 2'b01;
            m_in      = 2'(c >> 1);
            #1;
            er1 = (q1.size() < 2);
            er0 = (q0.size() == 0) || out_ready;
            total++; if (rdy1 !== er1) begin bad++; $display("FAIL rnd_rdy1 c=%0d got=%0h exp=%0h", c, rdy1, er1); end
            total++; if (ov1 !== (q1.size() != 0)) begin bad++; $display("FAIL rnd_ov1 c=%0d got=%0h exp=%0h", c, ov1, q1.size() != 0); end
            total++; if (occ1 !== 2'(q1.size())) begin bad++; $display("FAIL rnd_occ1 c=%0d got=%0h exp=%0h", c, occ1, q1.size()); end
            if (q1.size() != 0) begin
                total++; if ({wb1, alu1} !== q1[0]) begin bad++; $display("FAIL rnd_data1 c=%0d got=%0h exp=%0h", c, {wb1, alu1}, q1[0]); end
            end else begin
                total++; if ({wb1, m1} !== 4'd0) begin bad++; $display("FAIL rnd_bubble1 c=%0d got=%0h exp=0", c, {wb1, m1}); end
            end
            total++; if (rdy0 !== er0) begin bad++; $display("FAIL rnd_rdy0 c=%0d got=%0h exp=%0h", c, rdy0, er0); end
            total++; if (ov0 !== (q0.size() != 0)) begin bad++; $display("FAIL rnd_ov0 c=%0d got=%0h exp=%0h", c, ov0, q0.size() != 0); end
            total++; if (occ0 !== 2'(q0.size())) begin bad++; $display("FAIL rnd_occ0 c=%0d got=%0h exp=%0h", c, occ0, q0.size()); end
            if (q0.size() != 0) begin
                total++; if ({wb0, alu0} !== q0[0]) begin bad++; $display("FAIL rnd_data0 c=%0d got=%0h exp=%0h", c, {wb0, alu0}, q0[0]); end
            end else begin
                total++; if ({wb0, m0} !== 4'd0) begin bad++; $display("FAIL rnd_bubble0 c=%0d got=%0h exp=0", c, {wb0, m0}); end
            end
            out_ready = ~out_ready;
            #1;
            total++; if (rdy1 !== er1) begin bad++; $display("FAIL rnd_comb_path c=%0d got=%0h exp=%0h", c, rdy1, er1); end
            out_ready = ~out_ready;
            #1;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (q1.size() != 0 && out_ready) void'(q1.pop_front());
                if (in_valid && er1) q1.push_back({wb_in, alu_in});
                if (q0.size() != 0 && out_ready) void'(q0.pop_front());
                if (in_valid && er0) q0.push_back({wb_in, alu_in});
            end
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
